// File: rtl/timer.sv
// Loadable down-counting interval timer: loads a tick count on a start edge, resyncs the
// 1 Hz divider, pulses expired when done. Optional TIMER_RESTART_EN lets a start in RUN reload.
module timer #(
   parameter int WIDTH = 4
) (
   input  logic             Hz1_enable,
   input  logic [WIDTH-1:0] value,
   input  logic             start_timer,
   input  logic             Reset,
   output logic             expired,
   input  logic             clk,
   output logic             divider_reset
);

   // state | meaning
   // IDLE  | waiting for a start edge; ticks ignored, cnt holds
   // RUN   | counting ticks down to expiry
   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             start_prev_q;
   logic             expired_q, expired_d;
   logic             div_rst_q, div_rst_d;
   logic             start_ev;

   assign start_ev      = start_timer & ~start_prev_q;
   assign expired       = expired_q;
   assign divider_reset = div_rst_q;

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         start_prev_q <= 1'b0;
         expired_q    <= 1'b0;
         div_rst_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         start_prev_q <= start_timer;
         expired_q    <= expired_d;
         div_rst_q    <= div_rst_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      expired_d = 1'b0;
      div_rst_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_ev) begin
               cnt_d     = value;
               div_rst_d = 1'b1;
               state_d   = RUN;
            end
         end
         RUN: begin
`ifdef TIMER_RESTART_EN
            if (start_ev) begin
               cnt_d     = value;
               div_rst_d = 1'b1;
            end else
`endif
            // Zero load expires on the next edge without waiting for a tick.
            if (cnt_q == '0) begin
               expired_d = 1'b1;
               state_d   = IDLE;
            end else if (Hz1_enable) begin
               if (cnt_q == WIDTH'(1)) begin
                  cnt_d     = '0;
                  expired_d = 1'b1;
                  state_d   = IDLE;
               end else begin
                  cnt_d = cnt_q - WIDTH'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_timer.sv
// Directed bench for timer: per-cycle vector table plus hand-written reset sequences.
module tb_timer;

   logic       clk = 1'b0;
   logic       rst, start, tick;
   logic [3:0] val;
   logic       expired, divider_reset;

   int checks   = 0;
   int failures = 0;

   timer #(.WIDTH(4)) dut (
      .Hz1_enable   (tick),
      .value        (val),
      .start_timer  (start),
      .Reset        (rst),
      .expired      (expired),
      .clk          (clk),
      .divider_reset(divider_reset)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       start;
      logic       tick;
      logic [3:0] val;
      logic       exp_e;
      logic       exp_d;
   } vec_t;

   vec_t vecs[128];
   int   nvec = 0;

   task automatic add(input logic r, input logic s, input logic t, input logic [3:0] v,
                      input logic e, input logic d);
      vecs[nvec] = '{r, s, t, v, e, d};
      nvec++;
   endtask

   task automatic chk(input string nm, input int idx, input logic got, input logic want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s[%0d] got=%0b want=%0b", nm, idx, got, want);
      end
   endtask

   task automatic cyc(input logic r, input logic s, input logic t, input logic [3:0] v);
      @(negedge clk);
      rst = r; start = s; tick = t; val = v;
      @(posedge clk);
      #1;
   endtask

   logic restart_en;

   initial begin
`ifdef TIMER_RESTART_EN
      restart_en = 1'b1;
`else
      restart_en = 1'b0;
`endif
      rst = 1'b1; start = 1'b0; tick = 1'b0; val = '0;
      #1;
      chk("reset_expired", 0, expired, 1'b0);
      chk("reset_divrst", 0, divider_reset, 1'b0);

      // Reset held 4 cycles, then idle with ticks toggling.
      for (int i = 0; i < 4; i++) add(1, 0, i[0], 4'd0, 0, 0);
      for (int i = 0; i < 4; i++) add(0, 0, ~i[0], 4'd9, 0, 0);
      // value=6, start held 3 cycles, tick every cycle.
      add(0, 1, 1, 4'd6, 0, 1);
      add(0, 1, 1, 4'd6, 0, 0);
      add(0, 1, 1, 4'd6, 0, 0);
      add(0, 0, 1, 4'd6, 0, 0);
      add(0, 0, 1, 4'd6, 0, 0);
      add(0, 0, 1, 4'd6, 0, 0);
      add(0, 0, 1, 4'd6, 1, 0);
      add(0, 0, 1, 4'd6, 0, 0);
      // value=2, 2-cycle start, value changes mid-count, sparse ticks.
      add(0, 1, 0, 4'd2, 0, 1);
      add(0, 1, 1, 4'd9, 0, 0);
      add(0, 0, 0, 4'd9, 0, 0);
      add(0, 0, 1, 4'd7, 1, 0);
      add(0, 0, 1, 4'd7, 0, 0);
      add(0, 0, 1, 4'd7, 0, 0);
      // value=0 without ticks, then with ticks.
      add(0, 1, 0, 4'd0, 0, 1);
      add(0, 0, 0, 4'd0, 1, 0);
      add(0, 0, 0, 4'd0, 0, 0);
      add(0, 1, 1, 4'd0, 0, 1);
      add(0, 0, 1, 4'd0, 1, 0);
      add(0, 0, 1, 4'd0, 0, 0);
      // value=5, second start with value=3 after 2 ticks.
      add(0, 1, 1, 4'd5, 0, 1);
      add(0, 0, 1, 4'd5, 0, 0);
      add(0, 0, 1, 4'd5, 0, 0);
      add(0, 1, 1, 4'd3, 0, restart_en);
      add(0, 1, 1, 4'd3, 0, 0);
      add(0, 0, 1, 4'd3, ~restart_en, 0);
      add(0, 0, 1, 4'd3, restart_en, 0);
      add(0, 0, 1, 4'd3, 0, 0);
      // Start edge coinciding with the expiry edge of a value=1 interval.
      add(0, 1, 0, 4'd1, 0, 1);
      add(0, 0, 0, 4'd1, 0, 0);
      add(0, 1, 1, 4'd1, ~restart_en, restart_en);
      add(0, 1, 1, 4'd1, restart_en, 0);
      add(0, 0, 1, 4'd1, 0, 0);

      for (int i = 0; i < nvec; i++) begin
         cyc(vecs[i].rst, vecs[i].start, vecs[i].tick, vecs[i].val);
         chk("vec_expired", i, expired, vecs[i].exp_e);
         chk("vec_divrst", i, divider_reset, vecs[i].exp_d);
      end

      // Reset during the divider_reset pulse clears it without waiting for an edge.
      cyc(0, 1, 0, 4'd4);
      chk("seq_div_pulse", 0, divider_reset, 1'b1);
      #2 rst = 1'b1; start = 1'b0;
      #1;
      chk("seq_div_async", 0, divider_reset, 1'b0);
      cyc(0, 0, 0, 4'd4);

      // value=4, reset after 2 ticks, ticks continue: no expiry ever.
      cyc(0, 1, 0, 4'd4);
      chk("seq_mid_start", 0, divider_reset, 1'b1);
      cyc(0, 0, 1, 4'd4);
      cyc(0, 0, 1, 4'd4);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("seq_mid_rst_e", 0, expired, 1'b0);
      chk("seq_mid_rst_d", 0, divider_reset, 1'b0);
      cyc(1, 0, 1, 4'd4);
      for (int i = 0; i < 6; i++) begin
         cyc(0, 0, 1, 4'd4);
         chk("seq_after_rst", i, expired, 1'b0);
      end
      // A fresh start is still accepted after the abort.
      cyc(0, 1, 0, 4'd1);
      chk("seq_new_start", 0, divider_reset, 1'b1);
      cyc(0, 0, 1, 4'd1);
      chk("seq_new_expire", 0, expired, 1'b1);
      cyc(0, 0, 1, 4'd1);
      chk("seq_new_idle", 0, expired, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
